// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file read, operand select and opcode legalisation into a one-entry output register.
// Define OPERAND_BYPASS_EN to forward same-edge write data into the latched operands.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [2:0]       alu_ctrl_in,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       alu_ctrl,
  output logic             illegal_seen
);
`ifdef OPERAND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [WIDTH-1:0] rf [NREG];
  logic             accept, legal, hit_a, hit_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = alu_ctrl_in inside {3'b000, 3'b001, 3'b011, 3'b100};
  // forwarding only matters for non-zero addresses; register 0 always reads 0
  assign hit_a = BYPASS && wb_en && wb_addr == rs_addr;
  assign hit_b = BYPASS && wb_en && wb_addr == rt_addr;
  assign rd_a  = rs_addr == 5'd0 ? '0 : hit_a ? wb_data : rf[rs_addr];
  assign rd_b  = rt_addr == 5'd0 ? '0 : hit_b ? wb_data : rf[rt_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      a            <= '0;
      b            <= '0;
      alu_ctrl     <= 3'b000;
      illegal_seen <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      a            <= rd_a;
      b            <= use_imm ? imm : rd_b;
      alu_ctrl     <= legal ? alu_ctrl_in : 3'b000;
      illegal_seen <= illegal_seen || !legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed plus random stimulus checked against a behavioural model of the operand stage.
module tb_alu_operand_stage;
`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, in_ready, use_imm = 0, wb_en = 0, out_valid, out_ready = 1, illegal_seen;
  logic [4:0]  rs_addr = 0, rt_addr = 0, wb_addr = 0;
  logic [31:0] imm = 0, wb_data = 0, a, b;
  logic [2:0]  alu_ctrl_in = 0, alu_ctrl;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_rf [32];
  logic [31:0] ma, mb;
  logic [2:0]  mc;
  bit          mv, mill;
  always #5 clk = ~clk;
  alu_operand_stage #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .alu_ctrl_in(alu_ctrl_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .alu_ctrl(alu_ctrl), .illegal_seen(illegal_seen)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    ma = 0; mb = 0; mc = 0; mv = 0; mill = 0;
  endtask
  function automatic logic [31:0] src(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (BYP && wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction
  task automatic drive(input bit iv, input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] im,
                       input bit ui, input logic [2:0] op, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit ordy);
    in_valid = iv; rs_addr = rs; rt_addr = rt; imm = im; use_imm = ui; alu_ctrl_in = op;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, mv});
    chk({tag, ".a"}, a, ma);
    chk({tag, ".b"}, b, mb);
    chk({tag, ".alu_ctrl"}, {29'b0, alu_ctrl}, {29'b0, mc});
    chk({tag, ".illegal_seen"}, {31'b0, illegal_seen}, {31'b0, mill});
  endtask
  task automatic tick(input string tag);
    bit rdy;
    #1;
    rdy = !mv || out_ready;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
    if (in_valid && rdy) begin
      ma = src(rs_addr);
      mb = use_imm ? imm : src(rt_addr);
      case (alu_ctrl_in)
        3'd0, 3'd1, 3'd3, 3'd4: mc = alu_ctrl_in;
        default: begin mc = 3'd0; mill = 1; end
      endcase
      mv = 1;
    end else if (out_ready) mv = 0;
    if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask
  initial begin
    model_reset();
    #3;
    check_outs("reset");
    #9 rst_n = 1'b1;
    drive(1, 0, 0, 32'h77, 1, 3'd1, 0, 0, 0, 1);
    tick("first_accept");
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'hAA, 1);
    tick("write_r5");
    drive(1, 5, 0, 0, 0, 3'd0, 0, 0, 0, 1);
    tick("issue_r5");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    tick("write_r0");
    drive(1, 0, 0, 32'h1234, 1, 3'd3, 0, 0, 0, 1);
    tick("issue_r0_imm");
    drive(1, 5, 5, 0, 0, 3'd4, 0, 0, 0, 0);
    tick("stall_load");
    drive(1, 0, 0, 32'h5, 1, 3'd1, 1, 5, 32'h55, 0);
    tick("stall_hold");
    tick("stall_hold2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("drain");
    drive(1, 5, 0, 0, 0, 3'b110, 0, 0, 0, 1);
    tick("illegal_110");
    drive(1, 5, 5, 0, 0, 3'b001, 0, 0, 0, 1);
    tick("sticky1");
    drive(1, 0, 5, 0, 0, 3'b011, 0, 0, 0, 1);
    tick("sticky2");
    drive(0, 0, 0, 0, 0, 0, 1, 7, 32'h1, 1);
    tick("write_r7");
    drive(1, 7, 7, 0, 0, 3'd0, 1, 7, 32'hDEAD_BEEF, 1);
    tick("same_edge");
    drive(1, 7, 0, 0, 0, 3'd0, 0, 0, 0, 1);
    tick("after_write");
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 2) != 0);
      tick("random");
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 1);
    tick("prep_write_r5");
    drive(1, 5, 0, 0, 0, 3'b111, 0, 0, 0, 0);
    tick("prep_held");
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h99, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check_outs("post_reset");
    drive(1, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1);
    tick("r5_cleared");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/register data width.
REQ-002 The block SHALL have parameter NREG, default 32, number of architectural registers (address width 5).
REQ-003 The block SHALL have one clock, clk, and reset is asynchronous and active-low, rst_n.
REQ-004 Port list SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  issue request valid
- in_ready  output  1  stage can accept an issue
- rs_addr  input  5  source register for operand a
- rt_addr  input  5  source register for operand b
- imm  input  WIDTH  immediate operand
- use_imm  input  1  1 = b from imm, 0 = b from rt
- alu_ctrl_in  input  3  requested ALU operation code
- wb_en  input  1  register write enable
- wb_addr  input  5  register write address
- wb_data  input  WIDTH  register write data
- out_valid  output  1  a/b/alu_ctrl valid to ALU
- out_ready  input  1  ALU side consumes
- a  output  WIDTH  operand a
- b  output  WIDTH  operand b
- alu_ctrl  output  3  operation code to ALU
- illegal_seen  output  1  sticky illegal-opcode flag

Function
REQ-005 Register file SHALL hold NREG x WIDTH entries; reads of register 0 SHALL return 0; writes to register 0 SHALL be discarded.
REQ-006 Register write SHALL occur on the rising clk edge when wb_en=1, independent of the issue handshake.
REQ-007 Output stage SHALL be a single-entry pipeline register; in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-008 Issue accepted when in_valid && in_ready; on that edge a <= reg[rs_addr], b <= use_imm ? imm : reg[rt_addr], alu_ctrl <= mapped code, out_valid <= 1; latency 1 cycle.
REQ-009 On an edge with out_valid && out_ready and no accept, out_valid SHALL clear to 0; with simultaneous accept it SHALL stay 1 with new contents (full throughput, one issue per cycle).
REQ-010 While out_valid && !out_ready, a, b, alu_ctrl SHALL hold stable; a later register write SHALL NOT alter latched operands.
REQ-011 Legal codes 000 (add), 001 (sub), 011 (and), 100 (or) SHALL pass unchanged; codes 010, 101, 110, 111 SHALL be mapped to 000 and set illegal_seen to 1 on the accepting edge.
REQ-012 illegal_seen SHALL remain 1 until reset.
REQ-013 in_valid with in_ready=0 SHALL change no state (request not consumed; upstream holds it).

Reset
REQ-014 rst_n=0 SHALL asynchronously clear all NREG registers, a, b, alu_ctrl, out_valid, illegal_seen to 0.
REQ-015 Reset mid-transfer SHALL discard the held entry; no write during rst_n=0 SHALL take effect.
REQ-016 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-017 Macro OPERAND_BYPASS_EN SHALL select same-edge write/read forwarding.
REQ-018 With OPERAND_BYPASS_EN defined: accept with wb_en=1 and wb_addr (non-zero) equal to rs_addr/rt_addr SHALL latch wb_data into a/b.
REQ-019 Without it: the same case SHALL latch the pre-write register value; wb_data visible from the next accept.

Verification
REQ-020 Write reg5=0x0000_00AA, then issue rs=5, rt=0, use_imm=0, code 000 -> next cycle out_valid=1, a=0xAA, b=0, alu_ctrl=000.
REQ-021 Write reg0=0xFFFF_FFFF, issue rs=0, use_imm=1, imm=0x1234 -> a=0, b=0x1234.
REQ-022 Hold out_ready=0 with an entry valid, write reg5=0x55 -> in_ready=0, a stays 0xAA; out_ready=1 then out_valid=0 next cycle if no new issue.
REQ-023 Issue code 110 -> alu_ctrl=000, illegal_seen=1, remains 1 after further legal issues until rst_n=0.
REQ-024 Same-edge wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF, issue rs=7 (reg7 previously 0x1) -> a=0xDEAD_BEEF with OPERAND_BYPASS_EN, a=0x1 without.
REQ-025 Assert rst_n=0 while out_valid=1 -> out_valid, a, b, illegal_seen =0 immediately; reg5 reads 0 after release.
